// File: rtl/alu_pkg.sv
// Shared definitions for the ALU pattern checker: ALU opcodes, field widths,
// the run-control FSM state encoding and the flag-compare helper.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned BONUS_W = 3;
  localparam int unsigned ZCV_W   = 3;

  // Position of the zero flag inside an expected {zero,cout,overflow} field
  localparam int unsigned ZCV_ZERO_BIT = 2;

  // ALU_control opcodes
  localparam logic [OP_W-1:0] OP_AND  = 4'd0;
  localparam logic [OP_W-1:0] OP_OR   = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd6;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd7;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd12;
  localparam logic [OP_W-1:0] OP_NAND = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Only arithmetic ops produce meaningful carry/overflow, so only they are
  // checked on all three flags; everything else is checked on zero alone.
  function automatic logic op_checks_all_flags(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_chk_pipe.sv
// Expected-value delay line with per-stage valid bits.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_flush         synchronous clear of every valid bit (new entry dropped)
//   i_vld, i_data   entry entering the line
//   o_vld, o_data   entry leaving the line DEPTH cycles later
module alu_chk_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];

  // Shift register; flush kills the valid bits but data just keeps moving
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= i_vld & ~i_flush;
      r_data[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1] & ~i_flush;
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/alu_pattern_checker.sv
// Streams PAT_NUM stored patterns into an ALU under test, one per cycle, and
// compares the ALU's result/flags against the stored expectations.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, abort               run control (abort wins over start)
//   pat_addr                   pattern memory address (data returns 1 cycle later)
//   pat_src1/src2/op/bonus     stored stimulus
//   pat_result/pat_zcv         stored expected result and {zero,cout,overflow}
//   src1/src2/ALU_control/bonus_control   drive to the ALU
//   result/zero/cout/overflow  ALU response, DUT_LAT cycles after src*
//   busy/done/pass             run status
//   err_pulse/err_idx          per-mismatch strobe and pattern index
//   error_count                saturating mismatch count for the run
module alu_pattern_checker
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PAT_NUM = 16,
  parameter int unsigned DUT_LAT = 0,
  parameter int unsigned ERR_W   = 6,
  parameter int unsigned ADDR_W  = (PAT_NUM > 1) ? $clog2(PAT_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [ADDR_W-1:0]  pat_addr,
  input  logic [DATA_W-1:0]  pat_src1,
  input  logic [DATA_W-1:0]  pat_src2,
  input  logic [OP_W-1:0]    pat_op,
  input  logic [BONUS_W-1:0] pat_bonus,
  input  logic [DATA_W-1:0]  pat_result,
  input  logic [ZCV_W-1:0]   pat_zcv,
  output logic [DATA_W-1:0]  src1,
  output logic [DATA_W-1:0]  src2,
  output logic [OP_W-1:0]    ALU_control,
  output logic [BONUS_W-1:0] bonus_control,
  input  logic [DATA_W-1:0]  result,
  input  logic               zero,
  input  logic               cout,
  input  logic               overflow,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               err_pulse,
  output logic [ADDR_W-1:0]  err_idx,
  output logic [ERR_W-1:0]   error_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAT_NUM - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  localparam int unsigned       PIPE_W    = DATA_W + ZCV_W + OP_W + ADDR_W;

  state_e r_state;
  state_e w_state_nxt;

  logic [ADDR_W-1:0]  r_pat_addr;
  logic               r_fetch_vld;
  logic [ADDR_W-1:0]  r_fetch_idx;
  logic [DATA_W-1:0]  r_src1;
  logic [DATA_W-1:0]  r_src2;
  logic [OP_W-1:0]    r_op;
  logic [BONUS_W-1:0] r_bonus;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               r_err_pulse;
  logic [ADDR_W-1:0]  r_err_idx;
  logic [ERR_W-1:0]   r_err_cnt;

  logic [ADDR_W-1:0]  w_pat_addr_nxt;
  logic               w_fetch_vld_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_pass_nxt;
  logic [ERR_W-1:0]   w_err_cnt_nxt;
  logic               w_start_ok;

  logic [PIPE_W-1:0]  w_pipe_in;
  logic [PIPE_W-1:0]  w_pipe_out;
  logic               w_pipe_vld;
  logic [DATA_W-1:0]  w_exp_result;
  logic [ZCV_W-1:0]   w_exp_zcv;
  logic [OP_W-1:0]    w_exp_op;
  logic [ADDR_W-1:0]  w_exp_idx;
  logic [ZCV_W-1:0]   w_flags;
  logic               w_mismatch;
  logic               w_err_hit;
  logic               w_last_cmp;

  // Run may only (re)start from a quiescent state, and never alongside abort
  assign w_start_ok = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start)                    w_state_nxt = ST_ISSUE;
        ST_ISSUE:         if (r_pat_addr == LAST_ADDR)  w_state_nxt = ST_DRAIN;
        ST_DRAIN:         if (w_last_cmp)               w_state_nxt = ST_DONE;
        default:                                        w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs (next values of registered outputs) ----------------
  always_comb begin
    w_pat_addr_nxt  = r_pat_addr;
    w_fetch_vld_nxt = (r_state == ST_ISSUE) && !abort;
    w_busy_nxt      = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_pass_nxt      = w_done_nxt && (w_err_cnt_nxt == '0);
    if (w_start_ok) begin
      w_pat_addr_nxt = '0;
    end else if ((r_state == ST_ISSUE) && !abort && (r_pat_addr != LAST_ADDR)) begin
      w_pat_addr_nxt = r_pat_addr + ADDR_W'(1);
    end
  end

  // ---------------- fetch / issue ----------------
  // Memory returns data one cycle after the address, so the index and valid
  // travel alongside it before entering the expected-value line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat_addr  <= '0;
      r_fetch_vld <= 1'b0;
      r_fetch_idx <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_op        <= '0;
      r_bonus     <= '0;
    end else begin
      r_pat_addr  <= w_pat_addr_nxt;
      r_fetch_vld <= w_fetch_vld_nxt;
      r_fetch_idx <= r_pat_addr;
      if (r_fetch_vld) begin
        r_src1  <= pat_src1;
        r_src2  <= pat_src2;
        r_op    <= pat_op;
        r_bonus <= pat_bonus;
      end
    end
  end

  // ---------------- expected-value delay line ----------------
  // One stage to match the src register plus DUT_LAT for the ALU itself.
  assign w_pipe_in = {pat_result, pat_zcv, pat_op, r_fetch_idx};

  alu_chk_pipe #(
    .DEPTH (DUT_LAT + 1),
    .WIDTH (PIPE_W)
  ) u_chk_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (abort),
    .i_vld   (r_fetch_vld),
    .i_data  (w_pipe_in),
    .o_vld   (w_pipe_vld),
    .o_data  (w_pipe_out)
  );

  assign {w_exp_result, w_exp_zcv, w_exp_op, w_exp_idx} = w_pipe_out;

  // ---------------- compare ----------------
  assign w_flags = {zero, cout, overflow};

  always_comb begin
    w_mismatch = 1'b0;
    if (result != w_exp_result) begin
      w_mismatch = 1'b1;
    end else if (op_checks_all_flags(w_exp_op)) begin
      w_mismatch = (w_flags != w_exp_zcv);
    end else begin
      w_mismatch = (zero != w_exp_zcv[ZCV_ZERO_BIT]);
    end
  end

  // An abort in the compare cycle suppresses that compare too
  assign w_err_hit  = w_pipe_vld && w_mismatch && !abort;
  assign w_last_cmp = w_pipe_vld && (w_exp_idx == LAST_ADDR);

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (w_start_ok) begin
      w_err_cnt_nxt = '0;
    end else if (w_err_hit && (r_err_cnt != ERR_MAX)) begin
      w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
    end
  end

  // ---------------- status / error registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_idx   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_err_pulse <= w_err_hit;
      r_err_cnt   <= w_err_cnt_nxt;
      if (w_start_ok) begin
        r_err_idx <= '0;
      end else if (w_err_hit) begin
        r_err_idx <= w_exp_idx;
      end
    end
  end

  assign pat_addr      = r_pat_addr;
  assign src1          = r_src1;
  assign src2          = r_src2;
  assign ALU_control   = r_op;
  assign bonus_control = r_bonus;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_pulse     = r_err_pulse;
  assign err_idx       = r_err_idx;
  assign error_count   = r_err_cnt;

endmodule

// File: tb/tb_alu_pattern_checker.sv
// Directed bench: instance A (7 patterns, combinational ALU, 2-bit counter)
// and instance B (11 patterns, 3-cycle ALU, 6-bit counter).
module tb_alu_pattern_checker;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: returns {result, zero, cout, overflow}
  function automatic logic [34:0] alu_gold(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin {c, r} = {1'b0, a} + {1'b0, ~b} + 33'd1; v = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
    return {r, (r == 32'd0), c, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic        a_start = 1'b0, a_abort = 1'b0;
  logic [2:0]  a_pat_addr, a_pat_bonus, a_pat_zcv, a_bonus_ctl, a_err_idx;
  logic [31:0] a_pat_src1, a_pat_src2, a_pat_result, a_src1, a_src2, a_result;
  logic [3:0]  a_pat_op, a_alu_ctl;
  logic        a_zero, a_cout, a_ovf, a_busy, a_done, a_pass, a_err_pulse;
  logic [1:0]  a_err_cnt;
  logic [31:0] am_s1 [7], am_s2 [7], am_res [7];
  logic [3:0]  am_op [7];
  logic [2:0]  am_zcv [7];
  int          a_fault = 0;
  logic [34:0] a_g;

  always @(posedge clk) begin
    a_pat_src1   <= am_s1[a_pat_addr];
    a_pat_src2   <= am_s2[a_pat_addr];
    a_pat_op     <= am_op[a_pat_addr];
    a_pat_result <= am_res[a_pat_addr];
    a_pat_zcv    <= am_zcv[a_pat_addr];
    a_pat_bonus  <= a_pat_addr;
  end

  // Faulty ALU: 1 = ADD reports overflow 0, 2 = cout inverted, 3 = result LSB flipped except NOR
  always_comb begin
    a_g = alu_gold(a_alu_ctl, a_src1, a_src2);
    case (a_fault)
      1: if (a_alu_ctl == OP_ADD) a_g[0] = 1'b0;
      2: a_g[1] = ~a_g[1];
      3: if (a_alu_ctl != OP_NOR) a_g[3] = ~a_g[3];
      default: ;
    endcase
  end
  assign {a_result, a_zero, a_cout, a_ovf} = a_g;

  alu_pattern_checker #(.DATA_W(32), .PAT_NUM(7), .DUT_LAT(0), .ERR_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .pat_addr(a_pat_addr), .pat_src1(a_pat_src1), .pat_src2(a_pat_src2),
    .pat_op(a_pat_op), .pat_bonus(a_pat_bonus), .pat_result(a_pat_result), .pat_zcv(a_pat_zcv),
    .src1(a_src1), .src2(a_src2), .ALU_control(a_alu_ctl), .bonus_control(a_bonus_ctl),
    .result(a_result), .zero(a_zero), .cout(a_cout), .overflow(a_ovf),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_pulse(a_err_pulse),
    .err_idx(a_err_idx), .error_count(a_err_cnt)
  );

  // ---------------- instance B ----------------
  logic        b_start = 1'b0, b_abort = 1'b0;
  logic [3:0]  b_pat_addr, b_err_idx, b_pat_op, b_alu_ctl;
  logic [2:0]  b_pat_bonus, b_pat_zcv, b_bonus_ctl;
  logic [31:0] b_pat_src1, b_pat_src2, b_pat_result, b_src1, b_src2, b_result;
  logic        b_zero, b_cout, b_ovf, b_busy, b_done, b_pass, b_err_pulse;
  logic [5:0]  b_err_cnt;
  logic [31:0] bm_s1 [11], bm_s2 [11], bm_res [11];
  logic [3:0]  bm_op [11];
  logic [2:0]  bm_zcv [11];
  logic [34:0] b_d1, b_d2, b_d3;

  always @(posedge clk) begin
    b_pat_src1   <= bm_s1[b_pat_addr];
    b_pat_src2   <= bm_s2[b_pat_addr];
    b_pat_op     <= bm_op[b_pat_addr];
    b_pat_result <= bm_res[b_pat_addr];
    b_pat_zcv    <= bm_zcv[b_pat_addr];
    b_pat_bonus  <= b_pat_addr[2:0];
  end

  // 3-stage ALU that always gets the result LSB wrong
  always @(posedge clk) begin
    b_d1 <= alu_gold(b_alu_ctl, b_src1, b_src2) ^ 35'd8;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign {b_result, b_zero, b_cout, b_ovf} = b_d3;

  alu_pattern_checker #(.DATA_W(32), .PAT_NUM(11), .DUT_LAT(3), .ERR_W(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .pat_addr(b_pat_addr), .pat_src1(b_pat_src1), .pat_src2(b_pat_src2),
    .pat_op(b_pat_op), .pat_bonus(b_pat_bonus), .pat_result(b_pat_result), .pat_zcv(b_pat_zcv),
    .src1(b_src1), .src2(b_src2), .ALU_control(b_alu_ctl), .bonus_control(b_bonus_ctl),
    .result(b_result), .zero(b_zero), .cout(b_cout), .overflow(b_ovf),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_pulse(b_err_pulse),
    .err_idx(b_err_idx), .error_count(b_err_cnt)
  );

  // err_pulse recorders
  int a_q[$];
  int b_q[$];
  int b_cyc_q[$];
  always @(negedge clk) begin
    if (a_err_pulse === 1'b1) a_q.push_back(int'(a_err_idx));
    if (b_err_pulse === 1'b1) begin
      b_q.push_back(int'(b_err_idx));
      b_cyc_q.push_back(cyc);
    end
  end

  // Start a run on A, count busy cycles until done (bounded); optional re-start pulse while busy
  task automatic run_a(input int fault, input int restart_at, output int busy_n,
                       output logic [31:0] s1_at2, output logic [3:0] op_at3);
    a_fault = fault;
    a_q.delete();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    busy_n = 0; s1_at2 = '0; op_at3 = '0;
    for (int i = 0; i < 60; i++) begin
      if (a_done === 1'b1) break;
      if (busy_n == 2) s1_at2 = a_src1;
      if (busy_n == 3) op_at3 = a_alu_ctl;
      a_start = (busy_n == restart_at);
      if (a_busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    a_start = 1'b0;
    chk("a_done_seen", a_done, 1);
    @(negedge clk);
  endtask

  initial begin
    int busy_n, seq_err;
    logic [31:0] s1_at2;
    logic [3:0]  op_at3;
    bit found;

    am_op[0] = OP_AND;  am_s1[0] = 32'hF0F0_F0F0; am_s2[0] = 32'h0FF0_FF00;
    am_op[1] = OP_OR;   am_s1[1] = 32'h1234_0000; am_s2[1] = 32'h0000_5678;
    am_op[2] = OP_SUB;  am_s1[2] = 32'd5;         am_s2[2] = 32'd5;
    am_op[3] = OP_ADD;  am_s1[3] = 32'h7FFF_FFFF; am_s2[3] = 32'd1;
    am_op[4] = OP_SLT;  am_s1[4] = 32'hFFFF_FFFF; am_s2[4] = 32'd1;
    am_op[5] = OP_NOR;  am_s1[5] = 32'd0;         am_s2[5] = 32'd0;
    am_op[6] = OP_NAND; am_s1[6] = 32'hFFFF_FFFF; am_s2[6] = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) {am_res[i], am_zcv[i]} = alu_gold(am_op[i], am_s1[i], am_s2[i]);
    for (int i = 0; i < 11; i++) begin
      case (i % 4)
        0: bm_op[i] = OP_ADD;
        1: bm_op[i] = OP_SUB;
        2: bm_op[i] = OP_AND;
        default: bm_op[i] = OP_OR;
      endcase
      bm_s1[i] = 32'h1000_0000 * i + i;
      bm_s2[i] = 32'd7 * i;
      {bm_res[i], bm_zcv[i]} = alu_gold(bm_op[i], bm_s1[i], bm_s2[i]);
    end

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pat_addr", a_pat_addr, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_err_cnt", a_err_cnt, 0);
    chk("rst_src1", a_src1, 0);
    chk("rst_b_err_pulse", b_err_pulse, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run, with an ignored start while busy
    run_a(0, 3, busy_n, s1_at2, op_at3);
    chk("clean_busy_cycles", busy_n, 9);
    chk("clean_src1_first", s1_at2, 32'hF0F0_F0F0);
    chk("clean_op_second", op_at3, OP_OR);
    chk("clean_pass", a_pass, 1);
    chk("clean_err_cnt", a_err_cnt, 0);
    chk("clean_pulses", a_q.size(), 0);
    chk("clean_done_hold", a_done, 1);

    // ADD 0x7FFFFFFF+1 with overflow dropped
    run_a(1, -1, busy_n, s1_at2, op_at3);
    chk("ovf_pulses", a_q.size(), 1);
    chk("ovf_idx", (a_q.size() > 0) ? a_q[0] : -1, 3);
    chk("ovf_err_cnt", a_err_cnt, 1);
    chk("ovf_pass", a_pass, 0);

    // Wrong cout: ignored on logic ops, caught on SUB/ADD
    run_a(2, -1, busy_n, s1_at2, op_at3);
    chk("cout_pulses", a_q.size(), 2);
    chk("cout_idx0", (a_q.size() > 0) ? a_q[0] : -1, 2);
    chk("cout_idx1", (a_q.size() > 1) ? a_q[1] : -1, 3);
    chk("cout_err_cnt", a_err_cnt, 2);

    // Six faults into a 2-bit counter
    run_a(3, -1, busy_n, s1_at2, op_at3);
    chk("sat_pulses", a_q.size(), 6);
    chk("sat_last_idx", (a_q.size() > 5) ? a_q[5] : -1, 6);
    chk("sat_err_cnt", a_err_cnt, 3);
    chk("sat_pass", a_pass, 0);

    // Abort (with simultaneous start) at pat_addr 4
    a_q.delete();
    a_fault = 3;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_pat_addr == 3'd4) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("abort_reach_addr4", found, 1);
    a_abort = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_abort = 1'b0; a_start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_pulses", a_q.size(), 2);
    chk("abort_idx1", (a_q.size() > 1) ? a_q[1] : -1, 1);
    chk("abort_err_cnt_held", a_err_cnt, 2);

    // Rerun, then reset in DRAIN
    a_q.delete();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_pat_addr == 3'd6 && a_busy === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("rerun_reach_last", found, 1);
    @(negedge clk);
    chk("drain_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    a_q.delete();
    chk("mrst_busy", a_busy, 0);
    chk("mrst_err_pulse", a_err_pulse, 0);
    chk("mrst_err_cnt", a_err_cnt, 0);
    chk("mrst_err_idx", a_err_idx, 0);
    chk("mrst_pat_addr", a_pat_addr, 0);
    chk("mrst_alu_ops", {a_src1, a_src2, a_alu_ctl, a_bonus_ctl}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mrst_no_pulse_after", a_q.size(), 0);
    chk("mrst_no_done", a_done, 0);
    chk("mrst_idle_busy", a_busy, 0);

    // Instance B: 3-cycle ALU, all patterns wrong
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 80; i++) begin
      if (b_done === 1'b1) break;
      if (b_busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("b_done", b_done, 1);
    chk("b_busy_cycles", busy_n, 16);
    chk("b_pulses", b_q.size(), 11);
    seq_err = 0;
    for (int i = 0; i < b_q.size(); i++) begin
      if (b_q[i] != i || b_cyc_q[i] != b_cyc_q[0] + i) seq_err++;
    end
    chk("b_idx_back_to_back", seq_err, 0);
    chk("b_err_cnt", b_err_cnt, 11);
    chk("b_pass", b_pass, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
